// File: rtl/muldiv_pkg.sv
// Package for the HI/LO multiply/divide sequencer.
// Holds the op encodings, FSM state encoding, per-iteration step selector,
// width/iteration defaults and the divide-by-zero LO pattern.
// Optional feature macro (used by the sequencer): MULDIV_EARLY_EXIT_EN.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_DEF  = 32;

  // LO value written when a divide has a zero divisor.
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } stateT;

  // Which iteration flavour the step block performs.
  typedef enum logic [1:0] {
    STEP_MUL_SHR = 2'd0,  // product/multiplier pair shifts right
    STEP_MUL_SHL = 2'd1,  // accumulate a left-shifting multiplicand
    STEP_DIV     = 2'd2   // restoring divide, one quotient bit
  } stepT;

  // Bit 1 of the op selects divide.
  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV (bit 0 clear) are the signed forms.
  function automatic logic opIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   stepOp   - iteration flavour (stepT encoding)
//   acc      - 2*WIDTH accumulator: {hi half, lo half}
//   operand  - multiplicand (shift-right form: low half; left-shift form:
//              full width shifted multiplicand) or divisor magnitude (low half)
//   mulBit   - current multiplier bit for the left-shift form
//   accNext  - accumulator after this iteration
//   qBit     - quotient bit produced by a divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]         stepOp,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] operand,
  input  logic               mulBit,
  output logic [2*WIDTH-1:0] accNext,
  output logic               qBit
);

  logic [WIDTH:0] sumHi;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trial;

  // Single iteration: add-and-shift multiply or compare-and-subtract divide.
  always_comb begin
    sumHi    = '0;
    remShift = '0;
    trial    = '0;
    accNext  = acc;
    qBit     = 1'b0;
    case (stepOp)
      STEP_MUL_SHR: begin
        // Carry out of the add lands in the top bit as the pair shifts right.
        sumHi   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, operand[WIDTH-1:0]} : {(WIDTH+1){1'b0}});
        accNext = {sumHi, acc[WIDTH-1:1]};
      end
      STEP_MUL_SHL: begin
        accNext = acc + (mulBit ? operand : {(2*WIDTH){1'b0}});
      end
      STEP_DIV: begin
        // Partial remainder shifted left can need WIDTH+1 bits.
        remShift = acc[2*WIDTH-1:WIDTH-1];
        trial    = remShift - {1'b0, operand[WIDTH-1:0]};
        if (!trial[WIDTH]) begin
          qBit    = 1'b1;
          accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
          qBit    = 1'b0;
          accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        accNext = acc;
        qBit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX-stage HI/LO resource.
// Shift-add multiply, restoring divide on operand magnitudes; signs are
// applied in FIX. HI/LO are written once, in the single DONE cycle.
// Optional macro MULDIV_EARLY_EXIT_EN: multiply uses a left-shifting
// multiplicand and leaves RUN as soon as the remaining multiplier is zero
// (at least one RUN cycle). Results are identical in both builds.
// Ports:
//   Clk, Rst (async, active low)
//   Start, Op, OpA, OpB - op request, sampled only in IDLE
//   Flush               - abort the op in flight
//   HiLoRead            - EX instruction reads HI/LO
//   Busy, Stall, Done   - status / pipeline hold / completion pulse
//   Hi_Write, Lo_Write, Hi_Out, Lo_Out - HI/LO register write port
//   DivByZero           - pulses with Done for a zero divisor
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = ITER_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             Hi_Write,
  output logic             Lo_Write,
  output logic [WIDTH-1:0] Hi_Out,
  output logic [WIDTH-1:0] Lo_Out,
  output logic             DivByZero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  stateT              stateR, stateNext;
  logic [1:0]         opR;
  logic [WIDTH-1:0]   aR, bR, bMagR;
  logic               signQR, signRR;
  logic [2*WIDTH-1:0] accR;
  logic [CW-1:0]      cntR;
  logic [WIDTH-1:0]   hiOutR, loOutR;
  logic               doneR, div0PulseR;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [2*WIDTH-1:0] mcandR;
  logic [WIDTH-1:0]   mplierR;
`endif

  logic               isDivS, isSignedS, divZeroS, runLastS;
  logic [WIDTH-1:0]   magAS, magBS;
  stepT               stepOpS;
  logic [2*WIDTH-1:0] stepOperandS, stepAccNextS;
  logic               stepMulBitS, stepQBitS;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]   hiFinalS, loFinalS;
  logic               fixCommitS;

  assign isDivS     = opIsDiv(opR);
  assign isSignedS  = opIsSigned(opR);
  assign divZeroS   = isDivS && (bR == {WIDTH{1'b0}});
  assign fixCommitS = (stateR == FIX) && !Flush;

  // Operand magnitudes for the signed forms; the unsigned forms pass through.
  always_comb begin
    magAS = aR;
    magBS = bR;
    if (isSignedS && aR[WIDTH-1]) begin
      magAS = -aR;
    end else begin
      magAS = aR;
    end
    if (isSignedS && bR[WIDTH-1]) begin
      magBS = -bR;
    end else begin
      magBS = bR;
    end
  end

  // Select the iteration flavour and operand feeding the step block.
  always_comb begin
    stepOpS      = STEP_DIV;
    stepOperandS = {{WIDTH{1'b0}}, bMagR};
    stepMulBitS  = 1'b0;
    if (isDivS) begin
      stepOpS      = STEP_DIV;
      stepOperandS = {{WIDTH{1'b0}}, bMagR};
      stepMulBitS  = 1'b0;
    end else begin
`ifdef MULDIV_EARLY_EXIT_EN
      stepOpS      = STEP_MUL_SHL;
      stepOperandS = mcandR;
      stepMulBitS  = mplierR[0];
`else
      stepOpS      = STEP_MUL_SHR;
      stepOperandS = {{WIDTH{1'b0}}, bMagR};
      stepMulBitS  = 1'b0;
`endif
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .stepOp  (stepOpS),
    .acc     (accR),
    .operand (stepOperandS),
    .mulBit  (stepMulBitS),
    .accNext (stepAccNextS),
    .qBit    (stepQBitS)
  );

  // Last RUN cycle: counter at ITER-1, or (early exit) multiplier exhausted.
  always_comb begin
    runLastS = (cntR == LAST_CNT);
`ifdef MULDIV_EARLY_EXIT_EN
    if (!isDivS && ((mplierR >> 1) == {WIDTH{1'b0}})) begin
      runLastS = 1'b1;
    end else begin
      runLastS = (cntR == LAST_CNT);
    end
`endif
  end

  // Sign fix-up and divide-by-zero override applied in FIX.
  always_comb begin
    prodS    = signQR ? -accR : accR;
    hiFinalS = prodS[2*WIDTH-1:WIDTH];
    loFinalS = prodS[WIDTH-1:0];
    if (!isDivS) begin
      hiFinalS = prodS[2*WIDTH-1:WIDTH];
      loFinalS = prodS[WIDTH-1:0];
    end else if (divZeroS) begin
      hiFinalS = aR;
      loFinalS = WIDTH'(DIV0_LO);
    end else begin
      loFinalS = signQR ? -accR[WIDTH-1:0] : accR[WIDTH-1:0];
      hiFinalS = signRR ? -accR[2*WIDTH-1:WIDTH] : accR[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic; Flush returns any non-IDLE state to IDLE.
  always_comb begin
    stateNext = stateR;
    case (stateR)
      IDLE:    stateNext = (Start && !Flush) ? PREP : IDLE;
      PREP:    stateNext = Flush ? IDLE : RUN;
      RUN:     stateNext = Flush ? IDLE : (runLastS ? FIX : RUN);
      FIX:     stateNext = Flush ? IDLE : DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Operand latch, sign capture, iteration accumulator and result registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      opR    <= 2'b00;
      aR     <= '0;
      bR     <= '0;
      bMagR  <= '0;
      signQR <= 1'b0;
      signRR <= 1'b0;
      accR   <= '0;
      cntR   <= '0;
      hiOutR <= '0;
      loOutR <= '0;
`ifdef MULDIV_EARLY_EXIT_EN
      mcandR  <= '0;
      mplierR <= '0;
`endif
    end else begin
      case (stateR)
        IDLE: begin
          if (Start && !Flush) begin
            opR <= Op;
            aR  <= OpA;
            bR  <= OpB;
          end
        end
        PREP: begin
          bMagR  <= magBS;
          signQR <= isSignedS & (aR[WIDTH-1] ^ bR[WIDTH-1]);
          signRR <= isSignedS & aR[WIDTH-1];
          cntR   <= '0;
`ifdef MULDIV_EARLY_EXIT_EN
          // Left-shift multiply accumulates into a cleared product.
          accR    <= isDivS ? {{WIDTH{1'b0}}, magAS} : {(2*WIDTH){1'b0}};
          mcandR  <= {{WIDTH{1'b0}}, magBS};
          mplierR <= magAS;
`else
          // Multiplier (or dividend) starts in the low half.
          accR <= {{WIDTH{1'b0}}, magAS};
`endif
        end
        RUN: begin
          accR <= stepAccNextS;
          cntR <= cntR + CW'(1);
`ifdef MULDIV_EARLY_EXIT_EN
          mcandR  <= mcandR << 1;
          mplierR <= mplierR >> 1;
`endif
        end
        FIX: begin
          if (!Flush) begin
            hiOutR <= hiFinalS;
            loOutR <= loFinalS;
          end
        end
        default: begin
          cntR <= cntR;
        end
      endcase
    end
  end

  // Completion pulses, registered so they coincide exactly with DONE.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      doneR      <= 1'b0;
      div0PulseR <= 1'b0;
    end else begin
      doneR      <= fixCommitS;
      div0PulseR <= fixCommitS && divZeroS;
    end
  end

  // Stall holds the front end while working (and in the Start cycle), but
  // releases in DONE so a dependent MFHI/MFLO can proceed next cycle.
  always_comb begin
    Busy  = (stateR != IDLE);
    Stall = Rst & ~Flush &
            (((stateR != IDLE) & (stateR != DONE)) |
             ((stateR != IDLE) & (stateR != DONE) & HiLoRead) |
             ((stateR == IDLE) & Start));
  end

  assign Done      = doneR;
  assign Hi_Write  = doneR;
  assign Lo_Write  = doneR;
  assign DivByZero = div0PulseR;
  assign Hi_Out    = hiOutR;
  assign Lo_Out    = loOutR;

  // The step's quotient bit is already folded into accNext.
  logic unusedQBit;
  assign unusedQBit = stepQBitS;

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle sequencer for the EX-stage HI/LO resource.
- Executes MULT/MULTU/DIV/DIVU iteratively: shift-add multiply, restoring divide.
- Asserts a pipeline stall while busy and writes HI/LO once on completion.
- Sits beside the ALU in EX. Its Hi_Write/Lo_Write/Hi_Out/Lo_Out feed the existing HI/LO register write port.

Parameters:
- WIDTH, 32, operand and result width.
- ITER, 32, RUN-state iterations (must equal WIDTH).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous active-low reset.
- Start  input  1  op request from ID/EX; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OpA  input  WIDTH  rs operand (forwarded value).
- OpB  input  WIDTH  rt operand (forwarded value).
- Flush  input  1  abort the op in flight (branch/jump flush).
- HiLoRead  input  1  the instruction in EX reads HI/LO (MFHI/MFLO).
- Busy  output  1  high in every state except IDLE.
- Stall  output  1  freezes PC, IF/ID and ID/EX.
- Done  output  1  one-cycle completion pulse.
- Hi_Write  output  1  HI write enable.
- Lo_Write  output  1  LO write enable.
- Hi_Out  output  WIDTH  HI write data.
- Lo_Out  output  WIDTH  LO write data.
- DivByZero  output  1  pulses with Done when a DIV/DIVU had OpB==0.

Behaviour:
- Reset (Rst low, async): state IDLE. All outputs 0, including Hi_Out/Lo_Out. Internal registers cleared. Takes effect mid-operation; no HI/LO write follows.
- States and transitions:
  - IDLE: Start=1 latches Op, OpA, OpB → PREP.
  - PREP (1 cycle): for signed ops, form magnitudes |A| and |B|; record signQ = A[31]^B[31] and signR = A[31]. Clear accumulator and counter.
  - RUN: one iteration per cycle. Counter 0..ITER-1. Exits to FIX after ITER cycles.
  - FIX (1 cycle): negate the 64-bit product if signQ (MULT only). For DIV, negate quotient if signQ and remainder if signR.
  - DONE (1 cycle): Done=1, Hi_Write=Lo_Write=1 with final Hi_Out/Lo_Out → IDLE.
- Latency: Start sampled at edge E0. PREP during cycle 1, RUN cycles 2..33, FIX cycle 34, DONE cycle 35. Accepting back-to-back: a new Start is sampled in the IDLE cycle following DONE.
- Multiply result: Hi = product[63:32], Lo = product[31:0]. Divide result: Lo = quotient, Hi = remainder.
- Divide by zero: Hi = OpA (original), Lo = 32'hFFFFFFFF, DivByZero=1 in DONE. Full latency is kept.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, with no flag.
- Stall = Busy & ~Flush, or Start in IDLE combinationally (so the following instruction holds). During DONE, Stall = 0 and the dependent MFHI/MFLO proceeds next cycle.
- HiLoRead while Busy keeps Stall high.
- Start while Busy is ignored; the ID/EX hold guarantees re-presentation.
- Flush in any non-IDLE state → IDLE at the next edge. No Done, no writes, Stall drops the same cycle.
- Flush and Start together in IDLE: Start is ignored.
- Hi_Write, Lo_Write, Done and DivByZero are never high outside DONE.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: multiply uses the left-shifting-multiplicand form. RUN exits to FIX at the first cycle where the remaining multiplier magnitude is 0, after a minimum of 1 RUN cycle. Divide is unchanged.
- Undefined: always ITER RUN cycles. Results are bit-identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: IDLE, PREP, RUN, FIX, DONE.
  - WIDTH/ITER defaults.
  - DIV0_LO constant 32'hFFFFFFFF.
- Sub-module muldiv_step: combinational single iteration. Inputs are op class, accumulator and operand; outputs are next accumulator and quotient bit. The sequencer owns the state, counter and sign logic.

Test Plan:
- MULT with OpA=-3 (FFFFFFFD), OpB=7 → Done in cycle 35, Hi=FFFFFFFF, Lo=FFFFFFEB. Stall high cycles 0..34.
- MULTU with OpA=FFFFFFFF, OpB=FFFFFFFF → Hi=FFFFFFFE, Lo=00000001. With MULDIV_EARLY_EXIT_EN: same result; MULTU 3×5 → Lo=0000000F, Done by cycle 6.
- DIV with OpA=-7, OpB=2 → Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU 100/7 → Lo=0000000E, Hi=00000002.
- DIVU with OpB=0, OpA=12345678 → Hi=12345678, Lo=FFFFFFFF, DivByZero pulse with Done.
- Flush at cycle 10 of a DIV → IDLE at the next edge, no Hi_Write/Lo_Write, Busy=0. A subsequent Start yields the correct result.
- Rst low at cycle 20 (asynchronous, between edges) → all outputs 0 immediately. After release, Start with OpA=0x80000000, OpB=FFFFFFFF (DIV) → Lo=80000000, Hi=0.
